// File: rtl/match_referee.sv
// Match referee: turns counter game-over events into per-side tallies and reports
// the match winner on a valid/ready handshake, while tracking per-game peak count.
module match_referee #(
    parameter int COUNT_SIZE    = 5,
    parameter int MATCH_WINS    = 3,
    parameter int TALLY_SIZE    = 3,
    parameter int MATCH_ID_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     gameover,
    input  logic [1:0]               who,
    input  logic [COUNT_SIZE-1:0]    count,
    output logic                     hold,
    output logic                     busy,
    output logic                     game_done,
    output logic [TALLY_SIZE-1:0]    w_games,
    output logic [TALLY_SIZE-1:0]    l_games,
    output logic [COUNT_SIZE-1:0]    peak,
    output logic                     err,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [1:0]               result_who,
    output logic [MATCH_ID_SIZE-1:0] result_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     gameover_d_q;
    logic                     game_done_q, game_done_d;
    logic [TALLY_SIZE-1:0]    w_games_q, w_games_d;
    logic [TALLY_SIZE-1:0]    l_games_q, l_games_d;
    logic [COUNT_SIZE-1:0]    peak_q, peak_d;
    logic                     err_q, err_d;
    logic                     result_valid_q, result_valid_d;
    logic [1:0]               result_who_q, result_who_d;
    logic [MATCH_ID_SIZE-1:0] result_id_q, result_id_d;
    logic                     hold_s, busy_s;

    logic edge_s, win_s, lose_s, bad_s, match_end_s;

    // A game only counts on the rising edge of gameover, so a level held across start is ignored.
    assign edge_s      = gameover & ~gameover_d_q;
    assign win_s       = edge_s & (who == 2'b10);
    assign lose_s      = edge_s & (who == 2'b01);
    assign bad_s       = edge_s & ~win_s & ~lose_s;
    assign match_end_s = (state_q == ST_PLAY) &
                         ((win_s  & (w_games_q == TALLY_SIZE'(MATCH_WINS - 1))) |
                          (lose_s & (l_games_q == TALLY_SIZE'(MATCH_WINS - 1))));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)        state_d = ST_PLAY;   else state_d = ST_IDLE;
            ST_PLAY:   if (match_end_s)  state_d = ST_REPORT; else state_d = ST_PLAY;
            ST_REPORT: if (result_ready) state_d = ST_IDLE;   else state_d = ST_REPORT;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs toward the counter stage.
    always_comb begin
        hold_s = 1'b1;
        busy_s = 1'b0;
        case (state_q)
            ST_IDLE:   begin hold_s = 1'b1; busy_s = 1'b0; end
            ST_PLAY:   begin hold_s = 1'b0; busy_s = 1'b1; end
            ST_REPORT: begin hold_s = 1'b1; busy_s = 1'b1; end
            default:   begin hold_s = 1'b1; busy_s = 1'b0; end
        endcase
    end

    // Tally, peak, error and result datapath.
    always_comb begin
        game_done_d    = 1'b0;
        w_games_d      = w_games_q;
        l_games_d      = l_games_q;
        peak_d         = peak_q;
        err_d          = err_q;
        result_valid_d = result_valid_q;
        result_who_d   = result_who_q;
        result_id_d    = result_id_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_games_d = {TALLY_SIZE{1'b0}};
                    l_games_d = {TALLY_SIZE{1'b0}};
                    peak_d    = {COUNT_SIZE{1'b0}};
                end else begin
                    peak_d = peak_q;
                end
            end
            ST_PLAY: begin
                if (win_s || lose_s) begin
                    game_done_d = 1'b1;
                    peak_d      = {COUNT_SIZE{1'b0}};
                    if (win_s) begin
                        w_games_d = w_games_q + TALLY_SIZE'(1);
                    end else begin
                        l_games_d = l_games_q + TALLY_SIZE'(1);
                    end
                    if (match_end_s) begin
                        result_valid_d = 1'b1;
                        result_who_d   = who;
                    end else begin
                        result_valid_d = result_valid_q;
                    end
                end else if (bad_s) begin
                    err_d = 1'b1;
                end else if (count > peak_q) begin
                    peak_d = count;
                end else begin
                    peak_d = peak_q;
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    result_who_d   = 2'b00;
                    result_id_d    = result_id_q + MATCH_ID_SIZE'(1);
                end else begin
                    result_valid_d = result_valid_q;
                end
            end
            default: begin
                game_done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; the edge register samples gameover in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gameover_d_q   <= 1'b0;
            game_done_q    <= 1'b0;
            w_games_q      <= {TALLY_SIZE{1'b0}};
            l_games_q      <= {TALLY_SIZE{1'b0}};
            peak_q         <= {COUNT_SIZE{1'b0}};
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
            result_who_q   <= 2'b00;
            result_id_q    <= {MATCH_ID_SIZE{1'b0}};
        end else begin
            gameover_d_q   <= gameover;
            game_done_q    <= game_done_d;
            w_games_q      <= w_games_d;
            l_games_q      <= l_games_d;
            peak_q         <= peak_d;
            err_q          <= err_d;
            result_valid_q <= result_valid_d;
            result_who_q   <= result_who_d;
            result_id_q    <= result_id_d;
        end
    end

    assign hold         = hold_s;
    assign busy         = busy_s;
    assign game_done    = game_done_q;
    assign w_games      = w_games_q;
    assign l_games      = l_games_q;
    assign peak         = peak_q;
    assign err          = err_q;
    assign result_valid = result_valid_q;
    assign result_who   = result_who_q;
    assign result_id    = result_id_q;

endmodule
